// File: rtl/elink_test_pkg.sv
// Shared types and constants for the eLink loopback test sequencer.
package elink_test_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } seq_state_e;

    localparam logic MODE_PAR = 1'b0;
    localparam logic MODE_SEQ = 1'b1;

    localparam logic [19:0] DEFAULT_TIMEOUT_CYCLES = 20'hFFFFF;

endpackage

// File: rtl/elink_test_sequencer_if.sv
// Per-channel start/done/error bundle between the sequencer (master) and the channel checkers (slave).
interface elink_test_sequencer_if #(
    parameter int unsigned N_CHAN = 3
);
    logic [N_CHAN-1:0] chan_start;
    logic [N_CHAN-1:0] chan_done;
    logic [N_CHAN-1:0] chan_error;

    modport master (
        output chan_start,
        input  chan_done,
        input  chan_error
    );

    modport slave (
        input  chan_start,
        output chan_done,
        output chan_error
    );
endinterface

// File: rtl/elink_test_watchdog.sv
// Per-phase watchdog: cleared on phase entry, counts while enabled, flags expiry at LIMIT.
module elink_test_watchdog
    import elink_test_pkg::*;
#(
    parameter int unsigned     TO_W  = 20,
    parameter logic [TO_W-1:0] LIMIT = '1
) (
    input  logic aclk,
    input  logic aresetn,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [TO_W-1:0] cnt_q;
    logic [TO_W-1:0] cnt_d;

    assign expired = en && (cnt_q == LIMIT);

    // Holds at LIMIT so a stalled phase keeps reporting expiry until it is cleared.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + TO_W'(1);
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/elink_test_sequencer.sv
// eLink loopback test sequencer: INIT channel first, then traffic channels in parallel or in
// ascending order, with sticky error/timeout scoreboard. Watchdog built only with ELINK_SEQ_TIMEOUT_EN.
module elink_test_sequencer
    import elink_test_pkg::*;
#(
    parameter int unsigned     N_CHAN         = 3,
    parameter int unsigned     CNT_W          = 32,
    parameter int unsigned     TO_W           = 20,
    parameter logic [TO_W-1:0] TIMEOUT_CYCLES = TO_W'(DEFAULT_TIMEOUT_CYCLES)
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   start,
    input  logic                   seq_mode,
    elink_test_sequencer_if.master chan,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic                   fail,
    output logic [N_CHAN-1:0]      err_vec,
    output logic [N_CHAN-1:0]      timeout_vec,
    output logic [CNT_W-1:0]       cycle_count
);

    localparam int unsigned     IDX_W    = $clog2(N_CHAN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CHAN - 1);

    seq_state_e        state_q, state_d;
    logic              start_q;
    logic              mode_q, mode_d;
    logic [IDX_W-1:0]  cur_q, cur_d;
    logic [N_CHAN-1:0] chan_start_q, chan_start_d;
    logic [N_CHAN-1:0] err_q, err_d;
    logic [N_CHAN-1:0] to_q, to_d;
    logic [N_CHAN-1:0] fin_q, fin_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              start_edge;
    logic              phase_active;
    logic              wd_clr;
    logic              wd_en;
    logic              wd_expired;
    logic [N_CHAN-1:0] pending;
    logic [N_CHAN-1:0] done_hit;
    logic [N_CHAN-1:0] to_hit;
    logic [N_CHAN-1:0] err_hit;

    assign start_edge   = start & ~start_q;
    assign phase_active = (state_q == INIT) || (state_q == RUN);
    assign wd_en        = phase_active && (|pending);

    // A channel is pending from its start until its first done or timeout.
    genvar gi;
    for (gi = 0; gi < N_CHAN; gi++) begin : g_chan
        assign pending[gi]  = chan_start_q[gi] & ~fin_q[gi];
        assign done_hit[gi] = pending[gi] & chan.chan_done[gi];
        assign to_hit[gi]   = pending[gi] & ~chan.chan_done[gi] & wd_expired;
        assign err_hit[gi]  = pending[gi] & chan.chan_error[gi];
    end

`ifdef ELINK_SEQ_TIMEOUT_EN
    elink_test_watchdog #(
        .TO_W  (TO_W),
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .aclk    (aclk),
        .aresetn (aresetn),
        .clr     (wd_clr),
        .en      (wd_en),
        .expired (wd_expired)
    );
`else
    logic unused_wd;
    assign wd_expired = 1'b0;
    assign unused_wd  = ^{TIMEOUT_CYCLES, wd_clr, wd_en};
`endif

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        cur_d        = cur_q;
        chan_start_d = chan_start_q;
        err_d        = err_q;
        to_d         = to_q;
        fin_d        = fin_q;
        cnt_d        = cnt_q;
        wd_clr       = 1'b0;

        if (phase_active) begin
            err_d = err_q | err_hit;
            to_d  = to_q | to_hit;
            fin_d = fin_q | done_hit | to_hit;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        case (state_q)
            IDLE, DONE: begin
                if (start_edge) begin
                    state_d      = INIT;
                    mode_d       = seq_mode;
                    cur_d        = IDX_W'(1);
                    chan_start_d = N_CHAN'(1);
                    err_d        = '0;
                    to_d         = '0;
                    fin_d        = '0;
                    cnt_d        = '0;
                    wd_clr       = 1'b1;
                end
            end
            INIT: begin
                // Decision uses this cycle's capture so a same-cycle error still blocks traffic.
                if (fin_d[0]) begin
                    wd_clr = 1'b1;
                    if (err_d[0] || to_d[0]) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                        if (mode_q == MODE_SEQ) begin
                            chan_start_d[1] = 1'b1;
                        end else begin
                            chan_start_d = '1;
                        end
                    end
                end
            end
            RUN: begin
                if (mode_q == MODE_SEQ) begin
                    if (fin_d[cur_q]) begin
                        if (cur_q == LAST_IDX) begin
                            state_d = DONE;
                        end else begin
                            cur_d               = cur_q + IDX_W'(1);
                            chan_start_d[cur_d] = 1'b1;
                            wd_clr              = 1'b1;
                        end
                    end
                end else if (&fin_d) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= IDLE;
            start_q      <= 1'b0;
            mode_q       <= MODE_PAR;
            cur_q        <= '0;
            chan_start_q <= '0;
            err_q        <= '0;
            to_q         <= '0;
            fin_q        <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            start_q      <= start;
            mode_q       <= mode_d;
            cur_q        <= cur_d;
            chan_start_q <= chan_start_d;
            err_q        <= err_d;
            to_q         <= to_d;
            fin_q        <= fin_d;
            cnt_q        <= cnt_d;
        end
    end

    assign chan.chan_start = chan_start_q;
    assign busy            = phase_active;
    assign done            = (state_q == DONE);
    assign pass            = done & ~(|err_q) & ~(|to_q);
    assign fail            = done & ((|err_q) | (|to_q));
    assign err_vec         = err_q;
    assign timeout_vec     = to_q;
    assign cycle_count     = cnt_q;

endmodule

// File: tb/tb_elink_test_sequencer.sv
// Self-checking bench for elink_test_sequencer: directed table, hand sequences and randomized runs
// against a scenario-level timing model. Timeout case is exercised when ELINK_SEQ_TIMEOUT_EN is defined.
module tb_elink_test_sequencer;
    import elink_test_pkg::*;

    localparam int N      = 4;
    localparam int CW     = 32;
    localparam int TO_LIM = 100;
    localparam int NEVER  = 100000;
    localparam int BUDGET = 3000;
`ifdef ELINK_SEQ_TIMEOUT_EN
    localparam bit TO_ON = 1'b1;
`else
    localparam bit TO_ON = 1'b0;
`endif

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic          start = 1'b0;
    logic          seq_mode = 1'b0;
    logic          busy, done, pass, fail;
    logic [N-1:0]  err_vec, timeout_vec;
    logic [CW-1:0] cycle_count;

    elink_test_sequencer_if #(.N_CHAN(N)) chan_if ();

    elink_test_sequencer #(
        .N_CHAN         (N),
        .CNT_W          (CW),
        .TO_W           (20),
        .TIMEOUT_CYCLES (20'd100)
    ) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .start       (start),
        .seq_mode    (seq_mode),
        .chan        (chan_if),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .fail        (fail),
        .err_vec     (err_vec),
        .timeout_vec (timeout_vec),
        .cycle_count (cycle_count)
    );

    always #5 aclk = ~aclk;

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

    int    n_checks = 0;
    int    n_pass   = 0;
    string cur_tag  = "reset";

    // Scenario: per-channel done delay and error offset (0 = no error), counted from that channel's start.
    logic         sc_mode;
    int           sc_d [N];
    int           sc_e [N];
    int           m_start [N];
    int           m_done;
    int           m_cnt;
    logic [N-1:0] m_err, m_to;
    logic         m_pass;

    typedef struct {
        logic         mode;
        int           d [N];
        int           e [N];
        logic [N-1:0] exp_err;
        logic         exp_pass;
        int           exp_cnt;
    } vec_t;

    vec_t tbl [5];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s %s: got %0d, expected %0d", cur_tag, name, act, exp);
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic chan_outcome(input int i, output int dur);
        int last;
        if (TO_ON && sc_d[i] > TO_LIM) begin
            dur      = TO_LIM + 1;
            m_to[i]  = 1'b1;
        end else begin
            dur = sc_d[i] + 1;
        end
        last = dur - 1;
        if (sc_e[i] != 0 && sc_e[i] <= last) m_err[i] = 1'b1;
    endtask

    // Each phase lasts (delay + 1) cycles; parallel takes the longest, sequential the sum.
    task automatic model_run();
        int t, dur, tmax;
        m_err = '0;
        m_to  = '0;
        for (int i = 0; i < N; i++) m_start[i] = -1;
        m_start[0] = 0;
        chan_outcome(0, dur);
        if (m_err[0] || m_to[0]) begin
            m_done = dur;
        end else begin
            t = dur;
            if (sc_mode == MODE_PAR) begin
                tmax = 0;
                for (int i = 1; i < N; i++) begin
                    m_start[i] = t;
                    chan_outcome(i, dur);
                    if (dur > tmax) tmax = dur;
                end
                m_done = t + tmax;
            end else begin
                for (int i = 1; i < N; i++) begin
                    m_start[i] = t;
                    chan_outcome(i, dur);
                    t = t + dur;
                end
                m_done = t;
            end
        end
        m_cnt  = m_done;
        m_pass = (m_err == '0) && (m_to == '0);
    endtask

    task automatic run_scen(input logic [N-1:0] exp_err, input logic [N-1:0] exp_to,
                            input logic exp_pass, input int exp_cnt, input int pulse_at);
        int           st [N];
        logic [N-1:0] seen, err_now, exp_mask;
        int           it, done_it;
        logic         got_done;
        model_run();
        chan_if.chan_done  = '0;
        chan_if.chan_error = '0;
        seq_mode = sc_mode;
        start    = 1'b0;
        step();
        start    = 1'b1;
        seen     = '0;
        got_done = 1'b0;
        done_it  = 0;
        it       = 0;
        for (int i = 0; i < N; i++) st[i] = -1;
        while (it < BUDGET && !got_done) begin
            step();
            it++;
            for (int i = 0; i < N; i++) begin
                if (!seen[i] && chan_if.chan_start[i]) begin
                    seen[i] = 1'b1;
                    st[i]   = it;
                end
            end
            if (it == 1) begin
                check("first_cycle_count", cycle_count, 0);
                check("first_busy", busy, 1);
            end
            if (done) begin
                got_done = 1'b1;
                done_it  = it;
            end else begin
                err_now = '0;
                for (int i = 0; i < N; i++) begin
                    if (seen[i]) begin
                        if (sc_d[i] < NEVER && it - st[i] >= sc_d[i]) chan_if.chan_done[i] = 1'b1;
                        if (sc_e[i] != 0 && it - st[i] == sc_e[i]) err_now[i] = 1'b1;
                    end
                end
                chan_if.chan_error = err_now;
                start = (it == pulse_at);
            end
        end
        check("done_reached", got_done, 1);
        if (got_done) begin
            exp_mask = '0;
            for (int i = 0; i < N; i++) if (m_start[i] >= 0) exp_mask[i] = 1'b1;
            check("done_latency", done_it - st[0], m_done);
            for (int i = 1; i < N; i++)
                check($sformatf("start_offset[%0d]", i), seen[i] ? st[i] - st[0] : -1, m_start[i]);
            check("err_vec", err_vec, exp_err);
            check("timeout_vec", timeout_vec, exp_to);
            check("pass", pass, exp_pass);
            check("fail", fail, !exp_pass);
            check("busy_in_done", busy, 0);
            check("cycle_count", cycle_count, exp_cnt);
            check("chan_start", chan_if.chan_start, exp_mask);
            repeat (3) step();
            check("count_frozen", cycle_count, exp_cnt);
            check("done_hold", done, 1);
        end
        $display("run %s mode=%0d err=%b to=%b pass=%0d cnt=%0d", cur_tag, sc_mode, err_vec,
                 timeout_vec, pass, cycle_count);
    endtask

    initial begin
        int pa;

        tbl[0].mode = MODE_PAR; tbl[0].d = '{20, 40, 55, 30}; tbl[0].e = '{0, 0, 0, 0};
        tbl[0].exp_err = 4'b0000; tbl[0].exp_pass = 1'b1; tbl[0].exp_cnt = 77;
        tbl[1].mode = MODE_SEQ; tbl[1].d = '{5, 10, 7, 3};    tbl[1].e = '{0, 0, 0, 0};
        tbl[1].exp_err = 4'b0000; tbl[1].exp_pass = 1'b1; tbl[1].exp_cnt = 29;
        tbl[2].mode = MODE_PAR; tbl[2].d = '{10, 5, 5, 5};    tbl[2].e = '{4, 0, 0, 0};
        tbl[2].exp_err = 4'b0001; tbl[2].exp_pass = 1'b0; tbl[2].exp_cnt = 11;
        tbl[3].mode = MODE_PAR; tbl[3].d = '{8, 12, 9, 6};    tbl[3].e = '{0, 12, 11, 0};
        tbl[3].exp_err = 4'b0010; tbl[3].exp_pass = 1'b0; tbl[3].exp_cnt = 22;
        tbl[4].mode = MODE_SEQ; tbl[4].d = '{3, 4, 4, 4};     tbl[4].e = '{0, 0, 0, 2};
        tbl[4].exp_err = 4'b1000; tbl[4].exp_pass = 1'b0; tbl[4].exp_cnt = 19;

        chan_if.chan_done  = '0;
        chan_if.chan_error = '0;
        repeat (2) step();
        check("reset_outputs", {busy, done, pass, fail}, 0);
        check("reset_vectors", {err_vec, timeout_vec, chan_if.chan_start}, 0);
        check("reset_count", cycle_count, 0);
        aresetn = 1'b1;
        step();

        for (int v = 0; v < 5; v++) begin
            cur_tag = $sformatf("tbl%0d", v);
            sc_mode = tbl[v].mode;
            for (int i = 0; i < N; i++) begin
                sc_d[i] = tbl[v].d[i];
                sc_e[i] = tbl[v].e[i];
            end
            run_scen(tbl[v].exp_err, 4'b0000, tbl[v].exp_pass, tbl[v].exp_cnt, 0);
        end

        // Abort in RUN: outputs must clear without waiting for a clock edge.
        cur_tag = "reset_mid_run";
        chan_if.chan_done  = '0;
        chan_if.chan_error = '0;
        seq_mode = MODE_PAR;
        start    = 1'b0;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        chan_if.chan_done[0] = 1'b1;
        step();
        chan_if.chan_done[0] = 1'b0;
        repeat (5) step();
        check("busy_before_reset", busy, 1);
        #3;
        aresetn = 1'b0;
        #1;
        check("async_chan_start", chan_if.chan_start, 0);
        check("async_flags", {busy, done, pass, fail}, 0);
        check("async_vectors", {err_vec, timeout_vec}, 0);
        check("async_count", cycle_count, 0);
        step();
        aresetn = 1'b1;
        step();
        cur_tag = "restart";
        sc_mode = tbl[1].mode;
        for (int i = 0; i < N; i++) begin
            sc_d[i] = tbl[1].d[i];
            sc_e[i] = tbl[1].e[i];
        end
        run_scen(tbl[1].exp_err, 4'b0000, tbl[1].exp_pass, tbl[1].exp_cnt, 0);

`ifdef ELINK_SEQ_TIMEOUT_EN
        cur_tag = "timeout";
        sc_mode = MODE_PAR;
        sc_d = '{10, 20, 30, NEVER};
        sc_e = '{0, 0, 0, 0};
        run_scen(4'b0000, 4'b1000, 1'b0, 112, 0);
`endif

        for (int r = 0; r < 24; r++) begin
            cur_tag = $sformatf("rand%0d", r);
            sc_mode = 1'($urandom_range(0, 1));
            for (int i = 0; i < N; i++) begin
                sc_d[i] = int'($urandom_range(1, 40));
                if ($urandom_range(0, 3) == 0) sc_e[i] = int'($urandom_range(1, sc_d[i] + 4));
                else sc_e[i] = 0;
            end
            model_run();
            pa = (m_done > 3) ? 2 + int'($urandom_range(0, m_done - 3)) : 0;
            run_scen(m_err, m_to, m_pass, m_cnt, pa);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/elink_test_sequencer.md
Name: elink_test_sequencer

Overview:
- Synthesizable sequencer and scoreboard for eLink loopback test channels; generalises the three-channel start/done/error harness to N_CHAN channels.
- Channel 0 is always the INIT channel. Channels 1..N_CHAN-1 are traffic channels, run either in parallel or one at a time.
- Latches sticky per-channel error and timeout flags, counts elapsed cycles, and reports one pass/fail verdict.
- Sits between the top-level test start and the per-channel traffic generator/checkers.

Parameters:
- N_CHAN, 3: number of channels, >=2; channel 0 is INIT.
- CNT_W, 32: width of the elapsed-cycle counter.
- TO_W, 20: width of the per-phase watchdog counter.
- TIMEOUT_CYCLES, 20'hFFFFF: watchdog limit in cycles per phase.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- start  in  1  level request; a rising edge begins a run.
- seq_mode  in  1  0 = traffic channels in parallel, 1 = sequential in ascending index; sampled at run start.
- chan_start  out  N_CHAN  per-channel start level.
- chan_done  in  N_CHAN  per-channel done level.
- chan_error  in  N_CHAN  per-channel error level.
- busy  out  1  run in progress.
- done  out  1  run complete.
- pass  out  1  valid while done=1.
- fail  out  1  valid while done=1.
- err_vec  out  N_CHAN  sticky error flags.
- timeout_vec  out  N_CHAN  sticky timeout flags.
- cycle_count  out  CNT_W  cycles from run start to done.

Behaviour:
- Reset, applied asynchronously:
  - State IDLE.
  - All outputs 0; no cycle_count exception.
  - Internal start edge register cleared.
  - Reset mid-run aborts immediately and drops chan_start.
- Start edge:
  - start is registered once; edge = start & ~start_q.
  - An edge is ignored outside IDLE and DONE.
- States:
  - IDLE: on edge, clear err_vec, timeout_vec and cycle_count; latch seq_mode; set chan_start[0]; go to INIT next cycle.
  - INIT: wait for chan_done[0] or timeout.
    - If err_vec[0] or timeout_vec[0] is set at exit, go to DONE; traffic channels are never started.
    - Otherwise go to RUN.
  - RUN, parallel: assert chan_start[N_CHAN-1:1] together. Exit when every active channel is done or timed out.
  - RUN, sequential: assert channel k; move to k+1 when k is done or timed out. Exit after N_CHAN-1 finishes.
  - DONE: done=1, busy=0.
    - pass = (err_vec==0)&&(timeout_vec==0); fail = ~pass.
    - chan_start and flags hold.
    - A new start edge re-enters via the IDLE clear actions, in a single cycle.
- chan_start is a level. Once set, a bit stays 1 until reset or the next run clear. Done channels are not restarted.
- busy = 1 in INIT and RUN.
- Error capture:
  - err_vec[i] is set when chan_start[i] & chan_error[i] & ~fin[i].
  - fin[i] is the registered done-or-timeout flag for channel i.
  - Error and done in the same cycle: the error is captured.
  - Errors after fin[i] are ignored.
- cycle_count:
  - Increments every cycle in INIT and RUN.
  - Saturates at all-ones; frozen in DONE.
- Phase latency:
  - chan_done[0] seen in cycle t gives RUN, and the traffic chan_start, at t+1.
  - The last traffic done in cycle t gives done=1 at t+1.

Optional Feature:
- ELINK_SEQ_TIMEOUT_EN defined:
  - The watchdog counter clears on every phase entry (INIT, each sequential channel, parallel RUN).
  - It increments while the phase is pending.
  - On reaching TIMEOUT_CYCLES, it sets timeout_vec and fin for every pending channel of that phase, and the phase completes next cycle.
- Undefined: no watchdog logic; timeout_vec is tied to 0; phases wait indefinitely.

Decomposition:
- Shared package elink_test_pkg holds:
  - state enum (IDLE, INIT, RUN, DONE);
  - mode constants MODE_PAR=0, MODE_SEQ=1;
  - default TIMEOUT_CYCLES.
- One natural sub-module, elink_test_watchdog: a clear/enable/expire counter, instantiated only under ELINK_SEQ_TIMEOUT_EN.

Test Plan:
- Parallel clean run, N_CHAN=3, seq_mode=0:
  - Stimulus: chan_done[0] 20 cycles after chan_start[0]; done[2:1] at 40 and 55 cycles after RUN.
  - Required: chan_start=3'b111 together; done=1, pass=1; cycle_count=~77.
- Sequential run, N_CHAN=4:
  - Required: chan_start[2] rises exactly 1 cycle after chan_done[1]; chan_start[3] rises 1 cycle after chan_done[2].
  - Required: pass=1.
- INIT failure:
  - Stimulus: chan_error[0] pulse before chan_done[0].
  - Required: chan_start[2:1] stay 0; err_vec=3'b001; fail=1.
- Simultaneous error and done:
  - Stimulus: chan_error[1] and chan_done[1] in the same cycle; chan_error[2] asserted after chan_done[2].
  - Required: err_vec=3'b010.
- Timeout, with ELINK_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=100:
  - Stimulus: chan_done[2] never asserts.
  - Required: timeout_vec=3'b100; done within 102 cycles of RUN; fail=1.
- Reset mid-RUN, then restart:
  - Stimulus: aresetn low mid-RUN.
  - Required: all outputs 0 asynchronously.
  - Stimulus: new start edge after reset release.
  - Required: cycle_count restarts at 0.
